im_loader: RTL
==============

# im_loader

Serial boot loader that receives a program image over a UART RX line (8N1) and writes it into instruction memory through that memory's write port (wvalid/waddr/wdata), which is otherwise tied off. It holds the core in reset until a complete, checksum-verified image has been written, then releases it. It sits in the top level between the serial pin and the instruction memory write port, and drives the core's reset.

## Interface
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- IMLEN, 1024: instruction memory size in bytes; must be a multiple of 4.
- IMALEN, $clog2(IMLEN): byte-address width.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_rx  in  1  asynchronous UART RX line; idles high.
- o_wvalid  out  1  one-cycle write strobe to instruction memory.
- o_waddr  out  IMALEN  byte address of the word write; always a multiple of 4.
- o_wdata  out  32  write data.
- o_core_rst  out  1  high while the core must be held in reset.
- o_done  out  1  image loaded; sticky until rst.
- o_err  out  1  any framing, length or checksum error since rst; sticky until rst.

## Operation
- RX front end:
  - i_rx passes through a 2-flop synchronizer.
  - Idle: wait for the synchronized line to go low.
  - Start bit: count CLKS_PER_BIT/2 cycles, then resample. If the line is high, it is a false start; return to idle with no byte and no error.
  - Data bits: sample 8 bits, one every CLKS_PER_BIT cycles, LSB first.
  - Stop bit: sample after another CLKS_PER_BIT cycles.
    - Stop = 1: pulse an internal byte_valid for one cycle, with the byte.
    - Stop = 0: framing error. Discard the byte, set o_err, and force the parser to WAIT_SYNC. Then return to idle.
- Frame format: 0xA5, LEN_LO, LEN_HI, 4×LEN payload bytes (each word little-endian), CSUM.
  - LEN is the word count.
  - CSUM is the XOR of all payload bytes. It excludes the sync and length bytes.
- Parser FSM, advancing only on byte_valid:
  - WAIT_SYNC: a byte of 0xA5 goes to LEN_LO. Any other byte is ignored.
  - LEN_LO: latch the low length byte, then go to LEN_HI.
  - LEN_HI: latch the high length byte.
    - LEN > IMLEN/4: set o_err and go to WAIT_SYNC.
    - LEN == 0: go to CSUM.
    - Otherwise: go to DATA.
    - On entry to DATA or CSUM, clear the word index and the running checksum.
  - DATA: shift each byte into bits [31:24] of a 32-bit assembler so that bytes land little-endian, and XOR it into the checksum.
    - On the 4th byte of a word, issue a write: o_wdata = the assembled word, o_waddr = word index × 4, o_wvalid = 1. Then increment the word index.
    - After word LEN−1 is written, go to CSUM.
  - CSUM:
    - Byte == running checksum: go to DONE.
    - Otherwise: set o_err and go to WAIT_SYNC.
    - Words already written remain in memory; a resent frame overwrites them.
  - DONE: terminal state. All further RX bytes are ignored, including 0xA5, until rst.
- o_core_rst = 1 in every state except DONE. o_done = 1 only in DONE.
- Reset (from any state, including mid-byte or mid-frame):
  - Every output returns to its reset value.
  - The RX and parser state return to idle / WAIT_SYNC.
  - The partial word assembly is discarded.
  - Memory contents are not touched.

## Timing
- Reset values: o_wvalid=0, o_waddr=0, o_wdata=0, o_core_rst=1, o_done=0, o_err=0.
- RX latency: byte_valid is asserted about 2 + (9.5 × CLKS_PER_BIT) cycles after the falling edge of the start bit appears on i_rx (±1 cycle of synchronizer uncertainty).
- Write timing:
  - o_wvalid is high for exactly one cycle, the cycle after the byte_valid of a word's 4th byte.
  - o_waddr and o_wdata are valid in that same cycle and hold until the next write.
- Final-byte timing: o_done rises, and o_core_rst falls, the cycle after byte_valid of a correct CSUM. o_err rises the cycle after the offending byte_valid or stop-bit sample.
- Writes are spaced at least 40 × CLKS_PER_BIT cycles apart; memory needs no backpressure.
- The word index never exceeds IMLEN/4 − 1; no address wrap is possible.

## Test plan
Use CLKS_PER_BIT=16 and IMLEN=1024 for all scenarios.
- Valid load: send A5 02 00 13 00 00 00 93 00 10 00 90.
  - Two one-cycle o_wvalid pulses: (addr 0x000, data 0x00000013), then (0x004, 0x00100093).
  - Then o_done=1, o_core_rst=0, o_err=0.
  - Leading noise bytes 00 FF before the A5 are ignored.
- Bad checksum: send the same frame with CSUM 91.
  - Two writes occur, then o_err=1, o_core_rst=1, o_done=0.
  - Resending the correct frame then gives o_done=1 with o_err still 1.
- Length limits:
  - A5 01 01 (LEN 257): o_err=1 and no o_wvalid.
  - A5 00 00 00 (LEN 0): o_done=1 with no writes.
- Framing and glitch:
  - A payload byte sent with stop bit 0: o_err=1 and the parser returns to WAIT_SYNC.
  - An RX low pulse of 4 cycles: no byte accepted and o_err stays 0.
- Reset mid-frame: assert rst for 1 cycle after 5 payload bytes.
  - All outputs return to their reset values.
  - A following valid 1-word frame writes addr 0x000.
- Post-done lock: after DONE, send a full valid frame. No o_wvalid occurs and o_done stays 1.

Source files
------------

// File: rtl/im_loader.sv
// im_loader: UART (8N1) boot loader. It receives a framed program image and
// writes it word by word into instruction memory. The core is held in reset
// until the whole image has been written and its checksum has matched.
//
// Frame: 0xA5, LEN_LO, LEN_HI, 4*LEN payload bytes (little-endian words), CSUM
// where CSUM is the XOR of the payload bytes only.
//
// Parser states:
//   state       | meaning
//   ------------+------------------------------------------------------------
//   P_WAIT_SYNC | hunting for the 0xA5 sync byte; other bytes are dropped
//   P_LEN_LO    | next byte is the low byte of the word count
//   P_LEN_HI    | next byte is the high byte; range-check LEN
//   P_DATA      | assemble payload words, one memory write per 4 bytes
//   P_CSUM      | next byte must equal the running XOR of the payload
//   P_DONE      | image accepted, core released; RX ignored until rst
module im_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int IMLEN        = 1024,
    parameter int IMALEN       = $clog2(IMLEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx,
    output logic              o_wvalid,
    output logic [IMALEN-1:0] o_waddr,
    output logic [31:0]       o_wdata,
    output logic              o_core_rst,
    output logic              o_done,
    output logic              o_err
);

    localparam int TW  = $clog2(CLKS_PER_BIT);
    localparam int WIW = IMALEN - 2;
    localparam logic [TW-1:0] T_FULL   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]   MAX_WORDS = 16'(IMLEN / 4);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        P_WAIT_SYNC,
        P_LEN_LO,
        P_LEN_HI,
        P_DATA,
        P_CSUM,
        P_DONE
    } p_state_t;

    rx_state_t        rx_state;
    logic             rx_s1;
    logic             rx_s2;
    logic [TW-1:0]    timer;
    logic [2:0]       bit_cnt;
    logic [7:0]       rx_shift;
    logic             byte_valid;
    logic             stop_bad;

    p_state_t         p_state;
    logic [7:0]       len_lo;
    logic [15:0]      len_m1;
    logic [WIW-1:0]   word_idx;
    logic [1:0]       byte_cnt;
    logic [31:0]      word_asm;
    logic [7:0]       csum;
    logic [15:0]      len_full;
    logic [31:0]      word_next;

    // A low stop-bit sample is seen by the parser in the same cycle it is
    // taken, so o_err rises on the following edge.
    assign stop_bad  = (rx_state == RX_STOP) && (timer == '0) && !rx_s2;
    assign len_full  = {rx_shift, len_lo};
    assign word_next = {rx_shift, word_asm[31:8]};

    // RX front end: synchronizer, mid-bit sampling with a down-counting bit timer
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_state   <= RX_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
        end else begin
            rx_s1      <= i_rx;
            rx_s2      <= rx_s1;
            byte_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s2) begin
                        timer    <= T_HALF;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (timer == '0) begin
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            timer    <= T_FULL;
                            bit_cnt  <= '0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                RX_DATA: begin
                    if (timer == '0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        timer    <= T_FULL;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                RX_STOP: begin
                    if (timer == '0) begin
                        byte_valid <= rx_s2;
                        rx_state   <= RX_IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Frame parser with registered memory-write and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            p_state    <= P_WAIT_SYNC;
            len_lo     <= '0;
            len_m1     <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word_asm   <= '0;
            csum       <= '0;
            o_wvalid   <= 1'b0;
            o_waddr    <= '0;
            o_wdata    <= '0;
            o_core_rst <= 1'b1;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_wvalid <= 1'b0;
            if (p_state == P_DONE) begin
                o_core_rst <= 1'b0;
                o_done     <= 1'b1;
            end else if (stop_bad) begin
                o_err   <= 1'b1;
                p_state <= P_WAIT_SYNC;
            end else if (byte_valid) begin
                case (p_state)
                    P_WAIT_SYNC: begin
                        if (rx_shift == 8'hA5) begin
                            p_state <= P_LEN_LO;
                        end
                    end
                    P_LEN_LO: begin
                        len_lo  <= rx_shift;
                        p_state <= P_LEN_HI;
                    end
                    P_LEN_HI: begin
                        len_m1   <= len_full - 16'd1;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        csum     <= '0;
                        if (len_full > MAX_WORDS) begin
                            o_err   <= 1'b1;
                            p_state <= P_WAIT_SYNC;
                        end else if (len_full == 16'd0) begin
                            p_state <= P_CSUM;
                        end else begin
                            p_state <= P_DATA;
                        end
                    end
                    P_DATA: begin
                        word_asm <= word_next;
                        csum     <= csum ^ rx_shift;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            o_wvalid <= 1'b1;
                            o_waddr  <= {word_idx, 2'b00};
                            o_wdata  <= word_next;
                            word_idx <= word_idx + WIW'(1);
                            if (16'(word_idx) == len_m1) begin
                                p_state <= P_CSUM;
                            end
                        end
                    end
                    P_CSUM: begin
                        if (rx_shift == csum) begin
                            p_state    <= P_DONE;
                            o_core_rst <= 1'b0;
                            o_done     <= 1'b1;
                        end else begin
                            o_err   <= 1'b1;
                            p_state <= P_WAIT_SYNC;
                        end
                    end
                    default: p_state <= P_WAIT_SYNC;
                endcase
            end
        end
    end

endmodule
